// File: rtl/stage_memory_pkg.sv
// Shared encodings for the memory stage: opcodes, load/store funct3 values and FSM states.
// Pure definitions; no latency or backpressure of its own.
package stage_memory_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_ECALL  = 7'b1110011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    function automatic logic is_link(input logic [6:0] op);
        return (op == OPC_JAL) || (op == OPC_JALR);
    endfunction

endpackage

// File: rtl/stage_memory_lsu_align.sv
// Byte-lane logic for the memory stage: store lane placement/strobes, load extraction, access legality.
// Purely combinational (0 cycles); no handshake of its own.
module lsu_align
    import stage_memory_pkg::*;
(
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rs2,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_ld_data,
    output logic        o_bad
);

    logic       w_ld_ok;
    logic       w_st_ok;
    logic       w_misalign;
    logic [7:0] w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_wdata = '0;
        o_wstrb = '0;
        case (i_funct3)
            F3_B: begin
                o_wdata = {4{i_rs2[7:0]}};
                o_wstrb = 4'b0001 << i_off;
            end
            F3_H: begin
                o_wdata = {2{i_rs2[15:0]}};
                o_wstrb = 4'b0011 << i_off;
            end
            F3_W: begin
                o_wdata = i_rs2;
                o_wstrb = 4'b1111;
            end
            default: ;
        endcase
    end

    assign w_ld_ok    = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W) ||
                        (i_funct3 == F3_BU) || (i_funct3 == F3_HU);
    assign w_st_ok    = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);
    // funct3[1:0] encodes the access size for every legal load/store
    assign w_misalign = ((i_funct3[1:0] == 2'b01) && i_off[0]) ||
                        ((i_funct3[1:0] == 2'b10) && (i_off != 2'b00));
    assign o_bad      = (i_is_load  && (!w_ld_ok || w_misalign)) ||
                        (i_is_store && (!w_st_ok || w_misalign));

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_ld_off)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: ;
        endcase
    end

    assign w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_ld_data = '0;
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_ld_data = i_rdata;
            F3_BU:   o_ld_data = {24'b0, w_byte};
            F3_HU:   o_ld_data = {16'b0, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// Memory-access stage: one dmem req/ack access per load/store, registered write-back record out.
// Latency 1 cycle (non-memory) or 2+ cycles (memory); holds in_ready low while an access is outstanding.
module stage_memory
    import stage_memory_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_res,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      addr_rd,
    input  logic            reg_write_back,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            fault
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_dmem_req;
    logic            r_dmem_we;
    logic [XLEN-1:0] r_dmem_addr;
    logic [XLEN-1:0] r_dmem_wdata;
    logic [3:0]      r_dmem_wstrb;
    logic [2:0]      r_ld_funct3;
    logic [1:0]      r_ld_off;
    logic [4:0]      r_rd;
    logic            r_rwb;
    logic            r_wb_we;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_fault;

    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_mem;
    logic            w_bad;
    logic            w_accept;
    logic            w_mem_go;
    logic            w_ack;
    logic [XLEN-1:0] w_wdata;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_ld_data;

    assign w_is_load  = (opcode == OPC_LOAD);
    assign w_is_store = (opcode == OPC_STORE);
    assign w_is_mem   = w_is_load || w_is_store;
    assign in_ready   = (r_state == ST_IDLE) || ((r_state == ST_FULL) && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_mem_go   = w_is_mem && !w_bad;
    assign w_ack      = (r_state == ST_MEM) && dmem_ack;

    lsu_align u_lsu_align (
        .i_is_load   (w_is_load),
        .i_is_store  (w_is_store),
        .i_funct3    (funct3),
        .i_off       (alu_res[1:0]),
        .i_rs2       (rs2),
        .i_ld_funct3 (r_ld_funct3),
        .i_ld_off    (r_ld_off),
        .i_rdata     (dmem_rdata),
        .o_wdata     (w_wdata),
        .o_wstrb     (w_wstrb),
        .o_ld_data   (w_ld_data),
        .o_bad       (w_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = w_mem_go ? ST_MEM : ST_FULL;
        end else begin
            case (r_state)
                ST_MEM:  if (dmem_ack)  w_state_nxt = ST_FULL;
                ST_FULL: if (out_ready) w_state_nxt = ST_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_wstrb <= '0;
            r_ld_funct3  <= '0;
            r_ld_off     <= '0;
            r_rd         <= '0;
            r_rwb        <= 1'b0;
            r_wb_we      <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_fault      <= 1'b0;
        end else if (w_accept && w_mem_go) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= w_is_store;
            r_dmem_addr  <= {alu_res[XLEN-1:2], 2'b00};
            r_dmem_wdata <= w_is_store ? w_wdata : '0;
            r_dmem_wstrb <= w_is_store ? w_wstrb : 4'b0000;
            r_ld_funct3  <= funct3;
            r_ld_off     <= alu_res[1:0];
            r_rd         <= addr_rd;
            r_rwb        <= reg_write_back;
        end else if (w_accept) begin
            // Non-memory record, or a load/store rejected as illegal/misaligned
            r_wb_we   <= w_is_mem ? 1'b0 : reg_write_back;
            r_wb_rd   <= addr_rd;
            r_wb_data <= w_is_mem ? '0 : (is_link(opcode) ? pc + XLEN'(4) : alu_res);
            r_fault   <= w_is_mem;
        end else if (w_ack) begin
            r_dmem_req <= 1'b0;
            r_wb_we    <= r_dmem_we ? 1'b0 : r_rwb;
            r_wb_rd    <= r_rd;
            r_wb_data  <= r_dmem_we ? '0 : w_ld_data;
            r_fault    <= 1'b0;
        end
    end

    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign dmem_wstrb = r_dmem_wstrb;
    assign out_valid  = (r_state == ST_FULL);
    assign wb_we      = r_wb_we;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign fault      = r_fault;

endmodule

// File: doc/stage_memory.md
# stage_memory

Memory-access stage directly downstream of the execute stage. Takes the execute result (ALU result / effective address, store data, destination register, write-back enable) and, for loads and stores, performs one access on the data-memory port via a req/ack handshake. It applies byte-lane alignment and load sign/zero extension, then presents a registered write-back record to the write-back stage under a valid/ready handshake. JAL/JALR link values (pc+4) are produced here; branch redirection (`br_taken`) is not handled by this block.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.

- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: execute record valid.
- `in_ready` out 1: stage can accept the record this cycle.
- `pc` in 32: pc of the instruction.
- `opcode` in 7: instruction opcode.
- `funct3` in 3: access size/sign, or ALU function.
- `alu_res` in 32: execute result / effective address.
- `rs2` in 32: store data.
- `addr_rd` in 5: destination register.
- `reg_write_back` in 1: execute requests an rd write (already 0 for rd=x0).
- `dmem_req` out 1: access request, held until ack.
- `dmem_we` out 1: 1 = store, 0 = load.
- `dmem_addr` out 32: word-aligned address (`alu_res` with [1:0] = 0).
- `dmem_wdata` out 32: lane-shifted store data.
- `dmem_wstrb` out 4: byte enables (0000 on loads).
- `dmem_ack` in 1: access complete; `dmem_rdata` valid this cycle.
- `dmem_rdata` in 32: load word.
- `out_valid` out 1: write-back record valid.
- `out_ready` in 1: write-back stage accepts.
- `wb_we` out 1: write `wb_data` to `wb_rd`.
- `wb_rd` out 5: destination register.
- `wb_data` out 32: result.
- `fault` out 1: misaligned or illegal access; instruction retired with no side effect.

## Operation
- States:
  - IDLE: empty.
  - MEM: access outstanding.
  - FULL: record held at the output.
- `in_ready` = (IDLE) or (FULL and `out_ready`). A record is accepted when `in_valid` and `in_ready` are both high.
- Accepting a record that is not a load or store goes to FULL:
  - JAL/JALR: `wb_data` = pc+4.
  - Otherwise: `wb_data` = `alu_res`.
  - `wb_we` = `reg_write_back`.
- Accepting an aligned load or store goes to MEM. The address, funct3, rd, we and store data are registered.
- Load funct3 decoding:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - 011, 110 and 111 are illegal.
- Store funct3 decoding:
  - 000 SB, 001 SH, 010 SW.
  - All other values are illegal.
- Misaligned: H access with addr[0]=1; W access with addr[1:0]≠0.
- An illegal or misaligned access goes to FULL with `fault`=1 and `wb_we`=0, and issues no dmem request.
- Store lanes:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 0011 << addr[1:0].
  - SW: wdata = rs2, wstrb = 1111.
- Load extraction: select the byte/half of `dmem_rdata` by addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- MEM with `dmem_ack` goes to FULL. Loads: `wb_data` = extracted value, `wb_we` = registered `reg_write_back`. Stores: `wb_we`=0, `wb_data`=0.
- FULL with `out_ready`: either accept a new record (same transitions as IDLE) or go to IDLE.
- `dmem_ack` outside MEM is ignored.
- While in MEM, `in_ready`=0 regardless of `out_ready`.

## Timing
- Reset values: `in_ready`=1 (IDLE); `dmem_req`, `dmem_we`, `out_valid`, `wb_we`, `fault` = 0; `dmem_addr`, `dmem_wdata`, `wb_data` = 0; `dmem_wstrb`=0; `wb_rd`=0.
- Reset asserted mid-access drops `dmem_req` immediately. A later stray ack is ignored.
- Non-memory record: accepted at edge T, `out_valid`=1 after edge T.
- Memory record: accepted at T, so `dmem_req`=1 from T+1. Ack at cycle T+1+k (k≥0) gives `out_valid`=1 from edge T+2+k. The minimum load/store latency is 2 cycles.
- `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` and `dmem_wstrb` are registered and stable from request through the ack cycle. `dmem_req` drops the cycle after the ack.
- The output record is stable while `out_valid` and not `out_ready`.
- Back-to-back non-memory records sustain 1 per cycle with `out_ready` held high.

## Structure
- Shared package contents:
  - Opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, ECALL).
  - Load/store funct3 encodings.
  - The 3-state FSM enum.
- One combinational sub-module, `lsu_align`, owns:
  - Store lane shifting and wstrb generation.
  - Load extraction and extension.
  - Misalign/illegal detection.
- The FSM and pipeline registers live in `stage_memory`.

## Test plan
- ADD record with alu_res=0x0000_1234, rd=5, reg_write_back=1 → one cycle later out_valid=1, wb_data=0x1234, wb_rd=5, wb_we=1. Repeat for 4 consecutive cycles with out_ready=1 → throughput of 1 per cycle.
- JAL at pc=0x100, rd=1 → wb_data=0x104, wb_we=1, no dmem_req.
- LB at addr 0x203, dmem_rdata=0x80FF_7F01, ack after 3 cycles → dmem_addr=0x200, wstrb=0, wb_data=0xFFFF_FF80. Repeat with LBU → 0x0000_0080.
- SH with rs2=0xAAAA_BEEF to 0x402, ack same cycle as req → wdata=0xBEEF_BEEF, wstrb=1100, wb_we=0. Check that in_ready stays 0 until FULL.
- LW at 0x301, and load with funct3=011 → fault=1, wb_we=0, dmem_req never asserts.
- Assert rst_n low during MEM, then pulse dmem_ack after release → all outputs at reset values, out_valid stays 0.
